// File: rtl/psum_buf_pkg.sv
// Shared definitions for the partial-sum line buffer: the partial-sum type,
// pointer-width helpers and the flattened lane layout that the MAC array
// and the output binariser also use.
package psum_buf_pkg;

  localparam int PSUM_W = 16;

  typedef logic [PSUM_W-1:0] psum_t;

  // Bits needed to index n entries; a single entry still gets a 1-bit index.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int count_w(input int n);
    return ptr_w(n + 1);
  endfunction

  // LSB of lane 'lane' of channel 'ch' in the fetch bus (KH lanes per channel).
  function automatic int fetch_lane_lsb(input int ch, input int lane, input int kh, input int dw);
    return (ch * kh + lane) * dw;
  endfunction

  // LSB of row 'row' of channel 'ch' in the store bus (KH-1 rows per channel).
  function automatic int store_lane_lsb(input int ch, input int row, input int kh, input int dw);
    return (ch * (kh - 1) + row) * dw;
  endfunction

endpackage

// File: rtl/psum_row_bank.sv
// One channel's worth of stored partial-sum rows: ROWS x IN_W entries with a
// single synchronous write port and a registered read port that can force
// its result to zero (used to mask the very first row of a frame).
module psum_row_bank
  import psum_buf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ROWS   = 2,
  parameter int IN_W   = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ptr_w(IN_W)-1:0]      wr_col,
  input  logic [ROWS*DATA_W-1:0]      wr_data,
  input  logic                        rd_en,
  input  logic                        rd_zero,
  input  logic [ptr_w(IN_W)-1:0]      rd_col,
  output logic [ROWS*DATA_W-1:0]      rd_data
);

  logic [DATA_W-1:0] mem [ROWS][IN_W];

  // Write every row of the addressed column at once; storage is not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        mem[r][wr_col] <= wr_data[r*DATA_W +: DATA_W];
      end
    end
  end

  // Registered read of the addressed column; reads see pre-write contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int r = 0; r < ROWS; r++) begin
        rd_data[r*DATA_W +: DATA_W] <= rd_zero ? '0 : mem[r][rd_col];
      end
    end
  end

endmodule

// File: rtl/partial_sum_line_buffer.sv
// Multi-channel line buffer for convolution partial sums. Holds KH-1 rows per
// channel across the input width. Shared read/write column pointers and an
// occupancy count make fetch and store hazard-free: a column is only
// rewritten after its current row was fetched, and only fetched after its
// previous-row value was stored.
module partial_sum_line_buffer
  import psum_buf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KH     = 3,
  parameter int KW     = 3,
  parameter int IN_W   = 32,
  parameter int CH     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          fetch_req,
  output logic                          fetch_ready,
  output logic                          fetch_valid,
  output logic [CH*KH*DATA_W-1:0]       fetch_vals,
  input  logic                          store_valid,
  output logic                          store_ready,
  input  logic [CH*(KH-1)*DATA_W-1:0]   store_vals,
  output logic [ptr_w(IN_W)-1:0]        col_base,
  output logic [count_w(IN_W)-1:0]      occupancy,
  output logic                          err
);

  localparam int ROWS    = KH - 1;
  localparam int CW      = ptr_w(IN_W);
  localparam int CW1     = CW + 1;
  localparam int OW      = count_w(IN_W);
  localparam int COL_OFF = IN_W - ((KW - 1) % IN_W);

  localparam logic [CW-1:0]  LAST_COL = CW'(IN_W - 1);
  localparam logic [CW-1:0]  ONE_COL  = CW'(1);
  localparam logic [OW-1:0]  FULL     = OW'(IN_W);
  localparam logic [OW-1:0]  ONE_OCC  = OW'(1);
  localparam logic [CW1-1:0] WIDTH_X  = CW1'(IN_W);
  localparam logic [CW1-1:0] OFF_X    = CW1'(COL_OFF);

  logic [CW-1:0]  rd_col;
  logic [CW-1:0]  wr_col;
  logic [OW-1:0]  occ;
  logic           first_row;
  logic           fetch_fire;
  logic           store_fire;
  logic [CW1-1:0] base_sum;

  assign fetch_ready = (occ < FULL);
  assign store_ready = (occ != '0);
  assign fetch_fire  = fetch_req & fetch_ready & ~clear;
  assign store_fire  = store_valid & store_ready & ~clear;
  assign occupancy   = occ;

  // Column pointers and the first-row mask; clear restarts the frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_col    <= '0;
      wr_col    <= '0;
      first_row <= 1'b1;
    end else if (clear) begin
      rd_col    <= '0;
      wr_col    <= '0;
      first_row <= 1'b1;
    end else begin
      if (fetch_fire) begin
        if (rd_col == LAST_COL) begin
          rd_col    <= '0;
          first_row <= 1'b0;
        end else begin
          rd_col <= rd_col + ONE_COL;
        end
      end
      if (store_fire) begin
        wr_col <= (wr_col == LAST_COL) ? '0 : wr_col + ONE_COL;
      end
    end
  end

  // Occupancy tracks fetched-but-not-yet-stored columns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      case ({fetch_fire, store_fire})
        2'b10:   occ <= occ + ONE_OCC;
        2'b01:   occ <= occ - ONE_OCC;
        default: occ <= occ;
      endcase
    end
  end

  // One-cycle valid pulse matching the registered bank read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_fire;
    end
  end

  // Sticky flag for a store offered while the buffer cannot take it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (store_valid && !store_ready) begin
      err <= 1'b1;
    end
  end

  // Column of the leftmost kernel tap: write column minus (KW-1), wrapped.
  always_comb begin
    base_sum = {1'b0, wr_col} + OFF_X;
    col_base = base_sum[CW-1:0];
    if (base_sum >= WIDTH_X) begin
      col_base = CW'(base_sum - WIDTH_X);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [ROWS*DATA_W-1:0] rd_rows;

    psum_row_bank #(
      .DATA_W (DATA_W),
      .ROWS   (ROWS),
      .IN_W   (IN_W)
    ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (store_fire),
      .wr_col  (wr_col),
      .wr_data (store_vals[store_lane_lsb(c, 0, KH, DATA_W) +: ROWS*DATA_W]),
      .rd_en   (fetch_fire),
      .rd_zero (first_row),
      .rd_col  (rd_col),
      .rd_data (rd_rows)
    );

    assign fetch_vals[fetch_lane_lsb(c, 0, KH, DATA_W) +: DATA_W]      = '0;
    assign fetch_vals[fetch_lane_lsb(c, 1, KH, DATA_W) +: ROWS*DATA_W] = rd_rows;
  end

endmodule

// File: tb/tb_partial_sum_line_buffer.sv
// Randomised and directed bench for partial_sum_line_buffer. Two instances
// (IN_W=4 and IN_W=5) share the stimulus; one is observed at a time against
// a model built on accepted fetch/store counts and a plain memory array.
module tb_partial_sum_line_buffer;

  localparam int DATA_W = 16;
  localparam int KH     = 3;
  localparam int KW     = 3;
  localparam int CH     = 2;
  localparam int FV_W   = CH * KH * DATA_W;
  localparam int SV_W   = CH * (KH - 1) * DATA_W;

  logic            clock;
  logic            reset;
  logic            clear;
  logic            fetch_req;
  logic            store_valid;
  logic [SV_W-1:0] store_vals;

  logic            fr4, fv4, sr4, err4;
  logic [FV_W-1:0] fvals4;
  logic [1:0]      cb4;
  logic [2:0]      occ4;

  logic            fr5, fv5, sr5, err5;
  logic [FV_W-1:0] fvals5;
  logic [2:0]      cb5;
  logic [2:0]      occ5;

  partial_sum_line_buffer #(
    .DATA_W(DATA_W), .KH(KH), .KW(KW), .IN_W(4), .CH(CH)
  ) dut4 (
    .clock(clock), .reset(reset), .clear(clear),
    .fetch_req(fetch_req), .fetch_ready(fr4), .fetch_valid(fv4), .fetch_vals(fvals4),
    .store_valid(store_valid), .store_ready(sr4), .store_vals(store_vals),
    .col_base(cb4), .occupancy(occ4), .err(err4)
  );

  partial_sum_line_buffer #(
    .DATA_W(DATA_W), .KH(KH), .KW(KW), .IN_W(5), .CH(CH)
  ) dut5 (
    .clock(clock), .reset(reset), .clear(clear),
    .fetch_req(fetch_req), .fetch_ready(fr5), .fetch_valid(fv5), .fetch_vals(fvals5),
    .store_valid(store_valid), .store_ready(sr5), .store_vals(store_vals),
    .col_base(cb5), .occupancy(occ5), .err(err5)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: which instance is observed, its width, accepted counts
  // since the last clear/reset, stored data and the expected registered outputs.
  bit              sel;
  int              w;
  int              rcnt;
  int              wcnt;
  logic [15:0]     mm [CH][KH-1][8];
  logic            exp_valid;
  logic [FV_W-1:0] exp_vals;
  logic            exp_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic doReset();
    #2;
    reset       = 1'b1;
    clear       = 1'b0;
    fetch_req   = 1'b0;
    store_valid = 1'b0;
    rcnt        = 0;
    wcnt        = 0;
    exp_valid   = 1'b0;
    exp_vals    = '0;
    exp_err     = 1'b0;
    #1;
    checkOutput("rst_occupancy", sel ? 128'(occ5) : 128'(occ4), 128'(0));
    checkOutput("rst_fetch_valid", sel ? 128'(fv5) : 128'(fv4), 128'(0));
    checkOutput("rst_fetch_vals", sel ? 128'(fvals5) : 128'(fvals4), 128'(0));
    checkOutput("rst_err", sel ? 128'(err5) : 128'(err4), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge against
  // the model, then advance the model by the handshakes that fire this cycle.
  task automatic applyStimulus(input logic freq, input logic sval, input logic clr,
                               input logic [SV_W-1:0] vals);
    int              occ;
    logic            fire_f;
    logic            fire_s;
    logic [FV_W-1:0] nv;
    fetch_req   = freq;
    store_valid = sval;
    clear       = clr;
    store_vals  = vals;
    @(negedge clock);
    occ = rcnt - wcnt;
    checkOutput("occupancy", sel ? 128'(occ5) : 128'(occ4), 128'(occ));
    checkOutput("fetch_ready", sel ? 128'(fr5) : 128'(fr4), 128'(occ < w));
    checkOutput("store_ready", sel ? 128'(sr5) : 128'(sr4), 128'(occ > 0));
    checkOutput("col_base", sel ? 128'(cb5) : 128'(cb4), 128'(((wcnt % w) - (KW - 1) + 2 * w) % w));
    checkOutput("fetch_valid", sel ? 128'(fv5) : 128'(fv4), 128'(exp_valid));
    checkOutput("fetch_vals", sel ? 128'(fvals5) : 128'(fvals4), 128'(exp_vals));
    checkOutput("err", sel ? 128'(err5) : 128'(err4), 128'(exp_err));

    fire_f = freq && (occ < w) && !clr;
    fire_s = sval && (occ > 0) && !clr;
    if (sval && !(occ > 0)) exp_err = 1'b1;

    nv = '0;
    for (int c = 0; c < CH; c++) begin
      for (int l = 1; l < KH; l++) begin
        nv[(c*KH + l)*DATA_W +: DATA_W] = (rcnt < w) ? 16'h0 : mm[c][l-1][rcnt % w];
      end
    end

    if (clr) begin
      rcnt      = 0;
      wcnt      = 0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = fire_f;
      if (fire_f) exp_vals = nv;
      if (fire_s) begin
        for (int c = 0; c < CH; c++) begin
          for (int r = 0; r < KH - 1; r++) begin
            mm[c][r][wcnt % w] = vals[(c*(KH-1) + r)*DATA_W +: DATA_W];
          end
        end
      end
      if (fire_f) rcnt++;
      if (fire_s) wcnt++;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [SV_W-1:0] roundTripVals(input int col);
    logic [SV_W-1:0] v;
    v = '0;
    v[(0*(KH-1) + 0)*DATA_W +: DATA_W] = 16'(16'h10 + col);
    v[(1*(KH-1) + 1)*DATA_W +: DATA_W] = 16'(16'h20 + col);
    return v;
  endfunction

  function automatic logic [SV_W-1:0] randVals();
    return {$urandom, $urandom};
  endfunction

  task automatic randomPhase(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 49) == 0, randVals());
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    fetch_req   = 1'b0;
    store_valid = 1'b0;
    store_vals  = '0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < KH - 1; r++)
        for (int k = 0; k < 8; k++)
          mm[c][r][k] = 16'h0;

    // Instance with IN_W=4.
    sel = 1'b0;
    w   = 4;
    @(posedge clock);
    #1;
    doReset();

    // First row masked, then a refused fifth fetch at full occupancy.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Round trip: store columns 0..3, then fetch them back.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, roundTripVals(i));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Drain to occupancy 1, then stream fetch+store for three rows.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, randVals());
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, randVals());

    // Clear with simultaneous fetch and store at occupancy 2.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, randVals());
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    // Illegal store at empty buffer; err survives clear and drops on reset.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, randVals());
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    randomPhase(400);

    // Instance with IN_W=5: fill, then fetch/store through the wrap.
    sel = 1'b1;
    w   = 5;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, randVals());
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    randomPhase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/partial_sum_line_buffer.md
# partial_sum_line_buffer

Parametrised, multi-channel line buffer for convolution partial sums. It holds KH-1 rows of partial sums per channel across the input width, and serves one column of stored partials on each fetch. It sits between the stochastic MAC array and the output binariser. Column indexing is internal, fetch and store are decoupled by valid/ready handshakes, and the read and write pointers are hazard-checked.

## Interface
Parameters:
- `DATA_W`, 16: partial-sum width (OUT_BIN_LEN).
- `KH`, 3: kernel height; the buffer stores KH-1 rows.
- `KW`, 3: kernel width; used only for `col_base` reporting.
- `IN_W`, 32: input width in columns; any value ≥2, not required to be a power of 2.
- `CH`, 4: parallel output channels; all channels share pointers.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `clear`, in, 1: synchronous frame restart.
- `fetch_req`, in, 1: request the next column.
- `fetch_ready`, out, 1: a fetch is accepted this cycle if `fetch_req` is also high.
- `fetch_valid`, out, 1: one-cycle pulse qualifying `fetch_vals`.
- `fetch_vals`, out, CH×KH×DATA_W: per channel; lane 0 is 0, lane i is stored row i-1.
- `store_valid`, in, 1: a store is offered.
- `store_ready`, out, 1: a store is accepted this cycle if `store_valid` is also high.
- `store_vals`, in, CH×(KH-1)×DATA_W: per channel; lane i is written to row i.
- `col_base`, out, clog2(IN_W): write column minus (KW-1), mod IN_W.
- `occupancy`, out, clog2(IN_W+1): R−W, where R and W are the accepted fetch and store counts.
- `err`, out, 1: sticky; set on `store_valid` while `store_ready` is low.

## Operation
- State is held in four registers:
  - `rd_col` and `wr_col`, each counting 0..IN_W-1 and wrapping to 0.
  - `occ` (0..IN_W).
  - `first_row`, set by reset or `clear` and cleared when `rd_col` wraps.
- Fetch handshake: `fetch_ready = (occ < IN_W)`. A fetch fires on `fetch_req && fetch_ready`:
  - It reads `mem[ch][i][rd_col]` for every channel and every row i.
  - It advances `rd_col`.
  - If `first_row` is high, all fetched lanes read as 0.
- Store handshake: `store_ready = (occ > 0)`. A store fires on `store_valid && store_ready`:
  - It writes `store_vals` to `mem[ch][i][wr_col]`.
  - It advances `wr_col`.
- Occupancy: `occ` increments on a fetch alone, decrements on a store alone, and is unchanged when both fire in the same cycle.
- Hazard freedom by construction:
  - A store never overwrites a column whose current row has not yet been fetched.
  - A fetch never reads a column whose previous-row store is still outstanding.
- No read/write bypass is needed. A same-cycle fetch and store at the same column index is impossible under the `occ` rules. If it ever occurs, the fetch returns the old contents (read-before-write).
- `clear`:
  - Zeroes `rd_col`, `wr_col` and `occ`, and sets `first_row`.
  - Takes priority over a simultaneous fetch or store, both of which are dropped.
  - Leaves memory contents as they are.
  - Does not clear `err`.
- `err` is cleared only by `reset`.

## Timing
- Fetch latency is 1 cycle. A fetch accepted at edge N produces `fetch_valid`=1 after edge N, held for exactly one cycle.
- `fetch_valid` has no back-pressure. The consumer must take the data in that cycle.
- Sustained throughput is one fetch and one store per cycle once `occ` > 0.
- `fetch_ready` and `store_ready` are combinational from registered `occ` only. There is no path from `fetch_req` or `store_valid` to either ready.
- Reset values:
  - `fetch_valid`=0, `fetch_vals`=0, `err`=0.
  - `occupancy`=0, so `fetch_ready`=1 and `store_ready`=0.
  - `col_base`=(IN_W-(KW-1)) mod IN_W.
  - `first_row`=1.
  - Memory is not reset, because `first_row` masks it.
- Reset asserted mid-frame: takes effect immediately. After deassertion the block behaves as after power-up.
- Full boundary: at `occ`=IN_W, a fetch alone is refused. A simultaneous store proceeds and `occ` drops to IN_W-1.

## Structure
- Shared package `psum_buf_pkg` holds:
  - `psum_t` (logic [DATA_W-1:0]).
  - The pointer-width helper functions.
  - The lane-layout constants used by the MAC array and the binariser.
- One sub-module `psum_row_bank`:
  - One channel's (KH-1)×IN_W storage.
  - One synchronous write port and one registered read port.
  - Instantiated CH times under a generate loop.
- The top level contains the counters, the occupancy/handshake logic, the `first_row` mask and `err`.

## Test plan
Use KH=3, IN_W=4, CH=2, DATA_W=16 unless noted.
- First row is masked: 4 fetches after reset → four `fetch_valid` pulses, every lane 0, `occupancy` 1,2,3,4. A 5th `fetch_req` → `fetch_ready`=0, no pulse.
- Data round-trip: store columns 0..3 with ch0 row0 = 0x10+col and ch1 row1 = 0x20+col, then fetch 4 → ch0 lane1 = 0x10..0x13, ch1 lane2 = 0x20..0x23, lane 0 = 0.
- Streaming: fetch and store every cycle for 3 rows at `occ`=1 → `occ` stays 1, no stall, `col_base` wraps 2,3,0,1.
- Illegal store: `store_valid` at `occ`=0 → memory unchanged, `err`=1; `err` stays 1 after `clear` and drops only on `reset`.
- Clear priority: `clear`, `fetch_req` and `store_valid` asserted together at `occ`=2 → `occ`=0, pointers 0, no `fetch_valid`; the next fetch returns zeros.
- Non-power-of-2 width: IN_W=5, fetch 10 columns → `rd_col` wraps 4→0, and data from the second row matches what was stored.
